// File: rtl/point_mul_seq_pkg.sv
// Shared definitions for the sequential scalar-point multiplier and its point adder.
// Curve: y^2 = x^3 + CURVE_A*x + 15 over GF(CURVE_P); b only matters when choosing points.
package point_mul_seq_pkg;

  localparam int DATAWIDTH = 8;

  // The point at infinity is encoded as (0,0); (0,0) is not on the curve because b != 0.
  localparam int INF_X = 0;
  localparam int INF_Y = 0;

  localparam int CURVE_P = 251;
  localparam int CURVE_A = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/point_mul_seq_adder.sv
// Combinational affine point adder over GF(CURVE_P); handles infinity, P == -Q and doubling.
// Field inversion uses Fermat's little theorem: a^(p-2) mod p.
module point_mul_seq_adder
  import point_mul_seq_pkg::*;
#(
  parameter int WIDTH = DATAWIDTH
) (
  input  logic [WIDTH-1:0] i_px,
  input  logic [WIDTH-1:0] i_py,
  input  logic [WIDTH-1:0] i_qx,
  input  logic [WIDTH-1:0] i_qy,
  output logic [WIDTH-1:0] o_rx,
  output logic [WIDTH-1:0] o_ry
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] MODP = PW'(CURVE_P);

  function automatic logic [WIDTH-1:0] modRed(input logic [PW-1:0] v);
    return WIDTH'(v % MODP);
  endfunction

  function automatic logic [WIDTH-1:0] modMul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return modRed(PW'(a) * PW'(b));
  endfunction

  function automatic logic [WIDTH-1:0] modAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return modRed(PW'(a) + PW'(b));
  endfunction

  // Operands are already reduced, so a + p - b never underflows.
  function automatic logic [WIDTH-1:0] modSub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return modRed(PW'(a) + MODP - PW'(b));
  endfunction

  function automatic logic [WIDTH-1:0] modInv(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] e;
    acc  = WIDTH'(1);
    base = a;
    e    = WIDTH'(MODP - PW'(2));
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) acc = modMul(acc, base);
      base = modMul(base, base);
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] w_px, w_py, w_qx, w_qy;
  logic             w_pInf, w_qInf;
  logic [WIDTH-1:0] w_lam;

  assign w_px   = modRed(PW'(i_px));
  assign w_py   = modRed(PW'(i_py));
  assign w_qx   = modRed(PW'(i_qx));
  assign w_qy   = modRed(PW'(i_qy));
  assign w_pInf = (i_px == WIDTH'(INF_X)) && (i_py == WIDTH'(INF_Y));
  assign w_qInf = (i_qx == WIDTH'(INF_X)) && (i_qy == WIDTH'(INF_Y));

  // Same x with different y (or y == 0 when doubling) means the sum is infinity.
  always_comb begin
    w_lam = '0;
    o_rx  = WIDTH'(INF_X);
    o_ry  = WIDTH'(INF_Y);
    if (w_pInf) begin
      o_rx = w_qx;
      o_ry = w_qy;
    end else if (w_qInf) begin
      o_rx = w_px;
      o_ry = w_py;
    end else if ((w_px == w_qx) && ((w_py != w_qy) || (w_py == '0))) begin
      o_rx = WIDTH'(INF_X);
      o_ry = WIDTH'(INF_Y);
    end else begin
      if (w_px == w_qx)
        w_lam = modMul(modAdd(modMul(WIDTH'(3), modMul(w_px, w_px)), WIDTH'(CURVE_A)),
                       modInv(modAdd(w_py, w_py)));
      else
        w_lam = modMul(modSub(w_qy, w_py), modInv(modSub(w_qx, w_px)));
      o_rx = modSub(modSub(modMul(w_lam, w_lam), w_px), w_qx);
      o_ry = modSub(modMul(w_lam, modSub(w_px, o_rx)), w_py);
    end
  end

endmodule

// File: rtl/point_mul_seq.sv
// Sequential scalar-point multiplier R = n*Q: MSB-first double-and-add on one shared adder.
// Every bit costs one DBL and one ADD cycle, so latency is always 2*WIDTH cycles.
module point_mul_seq
  import point_mul_seq_pkg::*;
#(
  parameter int WIDTH = DATAWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Rx_out,
  output logic [WIDTH-1:0] Ry_out,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           r_state;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;
  logic [WIDTH-1:0] r_nL, r_qx, r_qy;
  logic [WIDTH-1:0] r_accX, r_accY;
  logic [WIDTH-1:0] r_rx, r_ry;
  logic [IDX_W-1:0] r_idx;

  logic [WIDTH-1:0] w_opX, w_opY;
  logic [WIDTH-1:0] w_sumX, w_sumY;
  logic [WIDTH-1:0] w_selX, w_selY;
  logic             w_bit;

  // Doubling feeds the accumulator to both adder inputs; adding feeds the latched base point.
  assign w_opX = (r_state == ST_ADD) ? r_qx : r_accX;
  assign w_opY = (r_state == ST_ADD) ? r_qy : r_accY;

  point_mul_seq_adder #(.WIDTH(WIDTH)) uAdder (
    .i_px(r_accX),
    .i_py(r_accY),
    .i_qx(w_opX),
    .i_qy(w_opY),
    .o_rx(w_sumX),
    .o_ry(w_sumY)
  );

  // The add is always evaluated; the scalar bit only chooses whether its sum is kept.
  assign w_bit  = r_nL[r_idx];
  assign w_selX = w_bit ? w_sumX : r_accX;
  assign w_selY = w_bit ? w_sumY : r_accY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_nL       <= '0;
      r_qx       <= '0;
      r_qy       <= '0;
      r_accX     <= WIDTH'(INF_X);
      r_accY     <= WIDTH'(INF_Y);
      r_rx       <= '0;
      r_ry       <= '0;
      r_idx      <= IDX_TOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_nL      <= n;
            r_qx      <= Qx;
            r_qy      <= Qy;
            r_accX    <= WIDTH'(INF_X);
            r_accY    <= WIDTH'(INF_Y);
            r_idx     <= IDX_TOP;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_DBL;
          end
        end
        ST_DBL: begin
          r_accX  <= w_sumX;
          r_accY  <= w_sumY;
          r_state <= ST_ADD;
        end
        ST_ADD: begin
          r_accX <= w_selX;
          r_accY <= w_selY;
          if (r_idx == '0) begin
            r_rx       <= w_selX;
            r_ry       <= w_selY;
            r_outValid <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_DONE;
          end else begin
            r_idx   <= r_idx - IDX_W'(1);
            r_state <= ST_DBL;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign Rx_out    = r_rx;
  assign Ry_out    = r_ry;

endmodule

// File: tb/tb_point_mul_seq.sv
// Self-checking bench for point_mul_seq: table of scalar/point vectors plus hand-written
// sequences for backpressure, mid-operation reset and inputs changing after accept.
module tb_point_mul_seq;
  import point_mul_seq_pkg::*;

  localparam int W        = DATAWIDTH;
  localparam int P        = CURVE_P;
  localparam int A        = CURVE_A;
  localparam int GX       = 2;
  localparam int GY       = 5;
  localparam int MAX_WAIT = 4 * W + 16;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } point_t;

  typedef struct {
    string        name;
    logic [W-1:0] n;
    logic [W-1:0] qx;
    logic [W-1:0] qy;
    logic [W-1:0] expX;
    logic [W-1:0] expY;
  } vector_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] n, Qx, Qy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Rx_out, Ry_out;
  logic         busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  point_t  expQ[$];
  vector_t vecs[9];

  point_mul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .n        (n),
    .Qx       (Qx),
    .Qy       (Qy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Rx_out   (Rx_out),
    .Ry_out   (Ry_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference arithmetic: brute-force inverse and n repeated additions, unlike the RTL.
  function automatic int modp(input int v);
    int r;
    r = v % P;
    if (r < 0) r += P;
    return r;
  endfunction

  function automatic int invBrute(input int a);
    int r;
    r = 0;
    for (int k = 1; k < P; k++)
      if (modp(a * k) == 1) r = k;
    return r;
  endfunction

  function automatic point_t modelAdd(input point_t a, input point_t b);
    point_t r;
    int ax, ay, bx, by, lam, rx, ry;
    ax = int'(a.x); ay = int'(a.y); bx = int'(b.x); by = int'(b.y);
    if (ax == 0 && ay == 0) return b;
    if (bx == 0 && by == 0) return a;
    r.x = '0;
    r.y = '0;
    if (ax == bx && (ay != by || ay == 0)) return r;
    if (ax == bx) lam = modp(modp(3 * ax * ax + A) * invBrute(modp(2 * ay)));
    else          lam = modp(modp(by - ay) * invBrute(modp(bx - ax)));
    rx  = modp(lam * lam - ax - bx);
    ry  = modp(lam * (ax - rx) - ay);
    r.x = W'(rx);
    r.y = W'(ry);
    return r;
  endfunction

  function automatic point_t modelMul(input int k, input int qx, input int qy);
    point_t acc, q;
    acc.x = '0; acc.y = '0;
    q.x = W'(qx); q.y = W'(qy);
    for (int i = 0; i < k; i++) acc = modelAdd(acc, q);
    return acc;
  endfunction

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] vn, input logic [W-1:0] vx, input logic [W-1:0] vy,
                               input point_t exp, input bit push, output int acceptCycle);
    int guard;
    guard    = 0;
    n        = vn;
    Qx       = vx;
    Qy       = vy;
    in_valid = 1'b1;
    while (!in_ready && guard < MAX_WAIT) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkInt("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acceptCycle = cycle;
    in_valid    = 1'b0;
    if (push) expQ.push_back(exp);
  endtask

  task automatic waitResult(input string name, input int acceptCycle, input bit toggle);
    int guard, busyCount;
    guard     = 0;
    busyCount = 0;
    while (!out_valid && guard < MAX_WAIT) begin
      if (busy) busyCount++;
      if (toggle) begin
        n  = W'($urandom_range(255, 0));
        Qx = W'($urandom_range(255, 0));
        Qy = W'($urandom_range(255, 0));
      end
      @(posedge clk); #1;
      guard++;
    end
    checkVal({name, "_out_valid"}, W'(out_valid), W'(1));
    checkInt({name, "_latency"}, cycle - acceptCycle, 2 * W);
    checkInt({name, "_busy_cycles"}, busyCount, 2 * W);
  endtask

  task automatic checkOutput(input string name, output point_t exp);
    if (expQ.size() == 0) begin
      checkInt({name, "_scoreboard_entry"}, 0, 1);
      exp.x = '0; exp.y = '0;
    end else begin
      exp = expQ.pop_front();
      checkVal({name, "_Rx"}, Rx_out, exp.x);
      checkVal({name, "_Ry"}, Ry_out, exp.y);
    end
  endtask

  task automatic consumeResult(input string name, input point_t exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({name, "_handoff_out_valid"}, W'(out_valid), W'(0));
    checkVal({name, "_handoff_in_ready"}, W'(in_ready), W'(1));
    checkVal({name, "_kept_Rx"}, Rx_out, exp.x);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int     ac;
    point_t e, got;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n         = '0;
    Qx        = '0;
    Qy        = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_in_ready", W'(in_ready), W'(1));
    checkVal("reset_out_valid", W'(out_valid), W'(0));
    checkVal("reset_busy", W'(busy), W'(0));
    checkVal("reset_Rx", Rx_out, '0);
    checkVal("reset_Ry", Ry_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2G = (201,163) worked by hand: lambda = 13 * 10^-1 = 177 mod 251.
    e = modelMul(3, GX, GY);
    vecs[0] = '{"n0_G",   8'd0,   W'(GX), W'(GY), 8'd0,   8'd0};
    vecs[1] = '{"n0_2G",  8'd0,   8'd201, 8'd163, 8'd0,   8'd0};
    vecs[2] = '{"n1_G",   8'd1,   W'(GX), W'(GY), W'(GX), W'(GY)};
    vecs[3] = '{"n2_G",   8'd2,   W'(GX), W'(GY), 8'd201, 8'd163};
    vecs[4] = '{"n3_G",   8'd3,   W'(GX), W'(GY), e.x,    e.y};
    e = modelMul(255, GX, GY);
    vecs[5] = '{"nFF_G",  8'hFF,  W'(GX), W'(GY), e.x,    e.y};
    e = modelMul(128, GX, GY);
    vecs[6] = '{"n80_G",  8'h80,  W'(GX), W'(GY), e.x,    e.y};
    e = modelMul(165, 201, 163);
    vecs[7] = '{"nA5_2G", 8'hA5,  8'd201, 8'd163, e.x,    e.y};
    vecs[8] = '{"n1_2G",  8'd1,   8'd201, 8'd163, 8'd201, 8'd163};

    for (int i = 0; i < 9; i++) begin
      e.x = vecs[i].expX;
      e.y = vecs[i].expY;
      applyStimulus(vecs[i].n, vecs[i].qx, vecs[i].qy, e, 1'b1, ac);
      waitResult(vecs[i].name, ac, 1'b0);
      checkOutput(vecs[i].name, got);
      consumeResult(vecs[i].name, got);
    end

    // Backpressure: result held in DONE while a competing request is ignored.
    e = modelMul(5, GX, GY);
    applyStimulus(8'd5, W'(GX), W'(GY), e, 1'b1, ac);
    waitResult("bp", ac, 1'b0);
    checkOutput("bp", got);
    n        = 8'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkVal("bp_hold_Rx", Rx_out, e.x);
      checkVal("bp_hold_Ry", Ry_out, e.y);
      checkVal("bp_hold_out_valid", W'(out_valid), W'(1));
      checkVal("bp_hold_in_ready", W'(in_ready), W'(0));
    end
    n         = 8'd7;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal("bp_release_out_valid", W'(out_valid), W'(0));
    checkVal("bp_release_in_ready", W'(in_ready), W'(1));
    checkVal("bp_release_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    ac       = cycle;
    in_valid = 1'b0;
    checkVal("bp_next_busy", W'(busy), W'(1));
    checkVal("bp_next_in_ready", W'(in_ready), W'(0));
    expQ.push_back(modelMul(7, GX, GY));
    waitResult("bp_next", ac, 1'b0);
    checkOutput("bp_next", got);
    consumeResult("bp_next", got);

    // Asynchronous reset halfway through a multiplication.
    e.x = '0; e.y = '0;
    applyStimulus(8'hB7, W'(GX), W'(GY), e, 1'b0, ac);
    repeat (W) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkVal("rst_mid_in_ready", W'(in_ready), W'(1));
    checkVal("rst_mid_out_valid", W'(out_valid), W'(0));
    checkVal("rst_mid_busy", W'(busy), W'(0));
    checkVal("rst_mid_Rx", Rx_out, '0);
    checkVal("rst_mid_Ry", Ry_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'd3, W'(GX), W'(GY), modelMul(3, GX, GY), 1'b1, ac);
    waitResult("rst_n3", ac, 1'b0);
    checkOutput("rst_n3", got);
    consumeResult("rst_n3", got);

    // Inputs scrambled every cycle after the accept edge.
    applyStimulus(8'h5B, W'(GX), W'(GY), modelMul(91, GX, GY), 1'b1, ac);
    waitResult("toggle", ac, 1'b1);
    checkOutput("toggle", got);
    consumeResult("toggle", got);

    checkInt("scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
